// File: rtl/gcm_block_scheduler_if.sv
// gcm_block_scheduler_if: descriptor in, per-worker ready in, in-order block issue/status out
interface gcm_block_scheduler_if #(parameter int NUM_WORKERS = 4);
  logic start_valid;
  logic start_ready;
  logic [127:0] instance_size;
  logic last_instance;
  logic [NUM_WORKERS-1:0] worker_ready;
  logic issue_valid;
  logic [2:0] issue_worker;
  logic [127:0] counter;
  logic [2:0] phase;
  logic last;
  logic busy;
  logic done;
  logic error;
  logic burst_end;
  modport master (
    input start_valid, instance_size, last_instance, worker_ready,
    output start_ready, issue_valid, issue_worker, counter, phase, last, busy, done, error, burst_end
  );
  modport slave (
    output start_valid, instance_size, last_instance, worker_ready,
    input start_ready, issue_valid, issue_worker, counter, phase, last, busy, done, error, burst_end
  );
endinterface

// File: rtl/gcm_block_scheduler.sv
// gcm_block_scheduler: in-order GCM block issue to NUM_WORKERS workers; ports clk, rst (async high), bus (descriptor/ready in, issue/status out)
module gcm_block_scheduler #(
  parameter int NUM_WORKERS = 4,
  parameter int MAX_BLOCKS = 100000
) (
  input logic clk,
  input logic rst,
  gcm_block_scheduler_if.master bus
);
  localparam int KW = $clog2(MAX_BLOCKS + 1);
  localparam int WB = NUM_WORKERS > 1 ? $clog2(NUM_WORKERS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;
  state_t state, state_d;
  logic [KW-1:0] k, aad_blocks, total;
  logic last_inst, error_q;
  logic [65:0] aad_calc, text_calc, total_calc;
  logic accept, too_big, xfer, last_k;
  assign aad_calc = 66'(bus.instance_size[63:7]) + 66'(|bus.instance_size[6:0]);
  assign text_calc = 66'(bus.instance_size[127:71]) + 66'(|bus.instance_size[70:64]);
  assign total_calc = aad_calc + text_calc;
  assign accept = bus.start_valid && state == IDLE;
  assign too_big = total_calc > 66'(MAX_BLOCKS);
  assign last_k = k == total - KW'(1);
  assign xfer = state == ISSUE && bus.worker_ready[k[WB-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state == IDLE ? (accept && !too_big ? (total_calc == '0 ? FINISH : ISSUE) : IDLE)
            : state == ISSUE ? (xfer && last_k ? FINISH : ISSUE)
            : IDLE;
    bus.start_ready = state == IDLE;
    bus.busy = state != IDLE;
    bus.issue_valid = xfer;
    bus.issue_worker = state == ISSUE && NUM_WORKERS > 1 ? 3'(k[WB-1:0]) : 3'd0;
    bus.counter = state == ISSUE ? 128'(k) : '0;
    bus.last = state == ISSUE && last_k;
    bus.phase = state != ISSUE ? 3'b100
              : k < aad_blocks ? 3'b010
              : k == aad_blocks && last_k ? 3'b111
              : k == aad_blocks ? 3'b000
              : last_k ? 3'b011
              : 3'b001;
    bus.done = state == FINISH;
    bus.burst_end = state == FINISH && last_inst;
    bus.error = error_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
      aad_blocks <= '0;
      total <= '0;
      last_inst <= 1'b0;
      error_q <= 1'b0;
    end else begin
      error_q <= accept && too_big;
      if (accept && !too_big) begin
        k <= '0;
        aad_blocks <= KW'(aad_calc);
        total <= KW'(total_calc);
        last_inst <= bus.last_instance;
      end else if (xfer) begin
        k <= k + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_gcm_block_scheduler.sv
// tb_gcm_block_scheduler: directed scoreboard bench for gcm_block_scheduler
module tb_gcm_block_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gcm_block_scheduler_if #(.NUM_WORKERS(4)) bus();
  gcm_block_scheduler #(.NUM_WORKERS(4), .MAX_BLOCKS(100000)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int kind;
    logic [2:0] w;
    logic [127:0] k;
    logic [2:0] ph;
    logic last;
    logic burst;
    int gap;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_ev = 0;
  logic mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bus.burst_end) chk("burst_end_with_done", bus.done, 1);
      if (bus.issue_valid || bus.done || bus.error) begin
        exp_t e;
        int kind;
        kind = bus.issue_valid ? 0 : bus.done ? 1 : 2;
        if (q.size() == 0) chk("unexpected_event_kind", kind, 99);
        else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          if (e.gap != 0) chk("event_gap", cyc - last_ev, e.gap);
          if (kind == 0) begin
            chk("issue_worker", bus.issue_worker, e.w);
            chk("issue_counter", bus.counter, e.k);
            chk("issue_phase", bus.phase, e.ph);
            chk("issue_last", bus.last, e.last);
          end else if (kind == 1) begin
            chk("done_burst_end", bus.burst_end, e.burst);
            chk("done_busy", bus.busy, 1);
          end else begin
            chk("error_ready", bus.start_ready, 1);
          end
        end
        last_ev = cyc;
      end
    end
  end
  task automatic start(logic [63:0] aad, logic [63:0] txt, logic lst);
    int t = 0;
    while (!bus.start_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("start_timeout", t, 0);
    bus.instance_size = {txt, aad};
    bus.last_instance = lst;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
  endtask
  task automatic push_seq(int n, logic [23:0] ph, logic burst);
    for (int i = 0; i < n; i++)
      q.push_back('{0, 3'(i % 4), 128'(i), ph[3*i +: 3], i == n - 1, 1'b0, i == 0 ? 0 : 1});
    q.push_back('{1, 3'd0, 128'd0, 3'd0, 1'b0, burst, 1});
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !bus.start_ready) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", q.size(), 0);
  endtask
  initial begin
    int t;
    bus.start_valid = 1'b0;
    bus.instance_size = '0;
    bus.last_instance = 1'b0;
    bus.worker_ready = 4'hF;
    #1;
    chk("reset_ready", bus.start_ready, 1);
    chk("reset_valid", bus.issue_valid, 0);
    chk("reset_phase", bus.phase, 3'b100);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_error", bus.error, 0);
    chk("reset_counter", bus.counter, 0);
    chk("reset_burst_end", bus.burst_end, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start(64'd256, 64'd512, 1'b0);
    t = 0;
    while (!(bus.issue_valid && bus.counter == 128'd3) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mid_reached_k3", bus.counter, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.issue_valid, 0);
    chk("mid_rst_phase", bus.phase, 3'b100);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.start_ready, 1);
    chk("mid_rst_counter", bus.counter, 0);
    chk("mid_rst_done", bus.done, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done_hold", bus.done, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    push_seq(6, 24'o311022, 1'b0);
    start(64'd256, 64'd512, 1'b0);
    chk("accept_after_reset", bus.busy, 1);
    drain();
    push_seq(1, 24'o7, 1'b0);
    start(64'd0, 64'd100, 1'b0);
    drain();
    push_seq(3, 24'o222, 1'b1);
    start(64'd384, 64'd0, 1'b1);
    drain();
    bus.worker_ready = 4'b1011;
    push_seq(8, 24'o31111110, 1'b0);
    q[2].gap = 6;
    start(64'd0, 64'd1024, 1'b0);
    t = 0;
    while (!(bus.busy && bus.counter == 128'd2) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.issue_valid, 0);
      chk("stall_counter", bus.counter, 2);
      chk("stall_phase", bus.phase, 3'b001);
      chk("stall_worker", bus.issue_worker, 2);
      bus.worker_ready[0] = ~bus.worker_ready[0];
      @(posedge clk);
      #1;
    end
    bus.worker_ready = 4'hF;
    drain();
    q.push_back('{2, 3'd0, 128'd0, 3'd0, 1'b0, 1'b0, 0});
    start(64'd0, 64'd12800129, 1'b0);
    chk("err_pulse", bus.error, 1);
    chk("err_ready", bus.start_ready, 1);
    chk("err_busy", bus.busy, 0);
    drain();
    q.push_back('{1, 3'd0, 128'd0, 3'd0, 1'b0, 1'b1, 0});
    start(64'd0, 64'd0, 1'b1);
    chk("zero_done", bus.done, 1);
    chk("zero_burst_end", bus.burst_end, 1);
    chk("zero_valid", bus.issue_valid, 0);
    drain();
    push_seq(2, 24'o72, 1'b0);
    start(64'd1, 64'd1, 1'b0);
    drain();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
